// File: rtl/l2q_pkg.sv
// Shared types and constants for the L2 line request queue.
package l2q_pkg;

  localparam int unsigned LINE_ADDR_W = 26;
  localparam logic [31:0] CNT_MAX     = 32'hFFFF_FFFF;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } l2q_state_e;

endpackage

// File: rtl/line_addr_fifo.sv
// Line address FIFO: storage array, wrapping head/tail pointers and occupancy count.
module line_addr_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 26
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               head_data,
  output logic [W-1:0]               tail_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] tail_m1;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;
  assign tail_m1 = tail - PW'(1);

  assign head_data = mem[head];
  // Newest entry sits just behind the tail pointer.
  assign tail_data = mem[tail_m1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + PW'(1);
      if (do_pop)  head <= head + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= wdata;
  end

endmodule

// File: rtl/l2_line_req_queue.sv
// Queues cache line addresses and issues them to L2 over req/ack; keeps issue/drop stats.
// Optional build macro L2Q_COALESCE_EN absorbs inputs equal to the newest queued entry.
//
// state | meaning
// IDLE  | no request outstanding; launches the head entry when the queue is non-empty
// REQ   | l2_req held with l2_addr stable until l2_ack pops the head
module l2_line_req_queue
  import l2q_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = LINE_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [ADDR_W-1:0]          in_addr,
  output logic                       in_ready,
  output logic                       l2_req,
  output logic [ADDR_W-1:0]          l2_addr,
  input  logic                       l2_ack,
  output logic [$clog2(DEPTH):0]     count,
  output logic [31:0]                issued,
  output logic [31:0]                dropped
);

  l2q_state_e        state;
  l2q_state_e        next_state;
  logic              load_req;
  logic              pop;
  logic              push;
  logic              drop;
  logic              coalesce_hit;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W-1:0] head_data;
  logic [ADDR_W-1:0] tail_data;

`ifdef L2Q_COALESCE_EN
  assign coalesce_hit = in_valid && !fifo_empty && (in_addr == tail_data);
`else
  assign coalesce_hit = 1'b0;
`endif

  // Fullness comes from the registered count, so a same-cycle pop never rescues an input.
  assign push     = in_valid && !flush && !fifo_full && !coalesce_hit;
  assign drop     = in_valid && !flush && fifo_full && !coalesce_hit;
  assign in_ready = !fifo_full;

  line_addr_fifo #(
    .DEPTH (DEPTH),
    .W     (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush),
    .push      (push),
    .pop       (pop),
    .wdata     (in_addr),
    .head_data (head_data),
    .tail_data (tail_data),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     state <= IDLE;
    else if (flush) state <= IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_req   = 1'b0;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          load_req   = 1'b1;
          next_state = REQ;
        end
      end
      REQ: begin
        if (l2_ack) begin
          pop        = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l2_req  <= 1'b0;
      l2_addr <= '0;
    end else if (flush) begin
      l2_req  <= 1'b0;
      l2_addr <= '0;
    end else if (load_req) begin
      l2_req  <= 1'b1;
      l2_addr <= head_data;
    end else if (pop) begin
      l2_req  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued  <= '0;
      dropped <= '0;
    end else if (flush) begin
      issued  <= '0;
      dropped <= '0;
    end else begin
      if (pop && issued != CNT_MAX)   issued  <= issued + 32'd1;
      if (drop && dropped != CNT_MAX) dropped <= dropped + 32'd1;
    end
  end

endmodule

// File: tb/tb_l2_line_req_queue.sv
// Directed bench with an issue-order scoreboard checked by a negedge monitor.
module tb_l2_line_req_queue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [25:0] in_addr;
  logic        in_ready;
  logic        l2_req;
  logic [25:0] l2_addr;
  logic        l2_ack;
  logic [3:0]  count;
  logic [31:0] issued;
  logic [31:0] dropped;

  int          errors = 0;
  int          checks = 0;
  logic [25:0] exp_q[$];

  l2_line_req_queue #(.DEPTH(8), .ADDR_W(26)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_addr  (in_addr),
    .in_ready (in_ready),
    .l2_req   (l2_req),
    .l2_addr  (l2_addr),
    .l2_ack   (l2_ack),
    .count    (count),
    .issued   (issued),
    .dropped  (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted handshake must carry the next expected address.
  always @(negedge clk) begin
    if (rst_n && !flush && l2_req && l2_ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_order: got %0h expected none", l2_addr);
      end else begin
        if (l2_addr !== exp_q[0]) begin
          errors++;
          $display("FAIL issue_order: got %0h expected %0h", l2_addr, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  int n;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_addr = '0; l2_ack = 1'b0;
    #23;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_l2_req", 32'(l2_req), 32'd0);
    chk("rst_l2_addr", 32'(l2_addr), 32'd0);
    chk("rst_issued", issued, 32'd0);
    chk("rst_dropped", dropped, 32'd0);
    rst_n = 1'b1;
    repeat (3) step();
    chk("idle_no_req", 32'(l2_req), 32'd0);

    // Single request
    in_valid = 1'b1; in_addr = 26'h0000ABC; exp_q.push_back(26'h0000ABC);
    step();
    in_valid = 1'b0;
    chk("single_count1", 32'(count), 32'd1);
    chk("single_req_not_yet", 32'(l2_req), 32'd0);
    step();
    chk("single_req_up", 32'(l2_req), 32'd1);
    chk("single_addr", 32'(l2_addr), 32'h0000ABC);
    step();
    step();
    chk("single_req_held", 32'(l2_req), 32'd1);
    chk("single_addr_held", 32'(l2_addr), 32'h0000ABC);
    l2_ack = 1'b1;
    step();
    l2_ack = 1'b0;
    chk("single_req_down", 32'(l2_req), 32'd0);
    chk("single_issued", issued, 32'd1);
    chk("single_count0", 32'(count), 32'd0);

    // Overflow with no acks
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1; in_addr = 26'(i);
      if (i <= 8) exp_q.push_back(26'(i));
      step();
      if (i == 8) chk("ovf_in_ready_full", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_dropped", dropped, 32'd2);
    chk("ovf_req_head", 32'(l2_addr), 32'h1);

    // Push while acking at full: registered full still drops the input
    in_valid = 1'b1; in_addr = 26'h3FF; l2_ack = 1'b1;
    step();
    in_valid = 1'b0;
    chk("full_pushpop_dropped", dropped, 32'd3);
    chk("full_pushpop_count", 32'(count), 32'd7);
    chk("full_pushpop_issued", issued, 32'd2);

    n = 0;
    while (count != 0 && n < 40) begin
      step();
      n++;
    end
    l2_ack = 1'b0;
    chk("drain_cycles", 32'(n), 32'd14);
    chk("drain_issued", issued, 32'd9);
    step();
    chk("drain_req_low", 32'(l2_req), 32'd0);

    // Flush mid-request with concurrent input and ack
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_addr = 26'h100 + 26'(i);
      step();
    end
    in_valid = 1'b0;
    chk("pre_flush_req", 32'(l2_req), 32'd1);
    chk("pre_flush_count", 32'(count), 32'd5);
    flush = 1'b1; in_valid = 1'b1; in_addr = 26'h200; l2_ack = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; l2_ack = 1'b0;
    exp_q.delete();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_req", 32'(l2_req), 32'd0);
    chk("flush_addr", 32'(l2_addr), 32'd0);
    chk("flush_issued", issued, 32'd0);
    chk("flush_dropped", dropped, 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    repeat (3) step();
    chk("flush_nothing_queued", 32'(l2_req), 32'd0);

    // Duplicate inputs
    in_valid = 1'b1; in_addr = 26'h55; step();
    in_addr = 26'h55; step();
    in_addr = 26'h66; step();
    in_addr = 26'h66; step();
    in_valid = 1'b0;
`ifdef L2Q_COALESCE_EN
    exp_q.push_back(26'h55); exp_q.push_back(26'h66);
    chk("dup_count", 32'(count), 32'd2);
`else
    exp_q.push_back(26'h55); exp_q.push_back(26'h55);
    exp_q.push_back(26'h66); exp_q.push_back(26'h66);
    chk("dup_count", 32'(count), 32'd4);
`endif
    chk("dup_dropped", dropped, 32'd0);
    l2_ack = 1'b1;
    n = 0;
    while (count != 0 && n < 40) begin
      step();
      n++;
    end
    l2_ack = 1'b0;
`ifdef L2Q_COALESCE_EN
    chk("dup_issued", issued, 32'd2);
`else
    chk("dup_issued", issued, 32'd4);
`endif

    // Asynchronous reset while a request is outstanding
    in_valid = 1'b1; in_addr = 26'h77; step();
    in_valid = 1'b0; step();
    chk("pre_rst_req", 32'(l2_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(l2_req), 32'd0);
    chk("async_rst_addr", 32'(l2_addr), 32'd0);
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_issued", issued, 32'd0);
    exp_q.delete();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("post_rst_no_req", 32'(l2_req), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
